// File: rtl/mult4_accumulator.sv
// mult4_accumulator: multiplies 4-bit unsigned operand pairs, accumulates one frame
// of products, and offers the frame result on a valid/ready output.
// Latency: out_valid rises 2 cycles after the final input transfer (FLUSH, then HOLD).
// Backpressure: in_ready is 1 only in ACCUM; a held result (HOLD) stalls input until out_ready.
//
// Optional feature macro: MULT4_ACCUMULATOR_SATURATE_EN
//   defined   -> additions clamp at 2^ACC_W-1 and out_sat flags it (sticky per frame)
//   undefined -> additions wrap modulo 2^ACC_W and out_sat is tied to 0
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input beat handshake
//   in_a, in_b, in_last          4-bit operands and frame-closing flag
//   out_valid/out_ready          result handshake
//   out_acc, out_count, out_sat  frame sum, beat count, saturation flag
module mult4_accumulator #(
  parameter int ACC_W   = 12,
  parameter int COUNT_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {ACCUM = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;

  state_t state, state_nxt;

  logic             in_xfer;
  logic [7:0]       prod;
  logic             beat_final;

  // Product register P: one product in flight behind the multiplier
  logic [7:0]       p_prod;
  logic             p_last;
  logic             p_vld;

  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic [ACC_W-1:0] add_res;

  assign in_xfer = in_valid & in_ready;
  assign prod    = {4'b0000, in_a} * {4'b0000, in_b};

  // count already holds the beats accepted before this one
  assign beat_final = in_last | (count == 8'(COUNT_N - 1));

`ifdef MULT4_ACCUMULATOR_SATURATE_EN
  logic [ACC_W:0] sum_w;
  logic           add_ovf;
  logic           sat_acc;
  logic           out_sat_q;

  // One extra bit catches the carry out; clamp to all-ones on overflow
  assign sum_w   = {1'b0, acc} + (ACC_W + 1)'(p_prod);
  assign add_ovf = sum_w[ACC_W];
  assign add_res = add_ovf ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign out_sat = out_sat_q;
`else
  assign add_res = acc + ACC_W'(p_prod);
  assign out_sat = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (in_xfer && beat_final) state_nxt = FLUSH;
      FLUSH: state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      p_prod    <= '0;
      p_last    <= 1'b0;
      p_vld     <= 1'b0;
      acc       <= '0;
      count     <= '0;
      out_acc   <= '0;
      out_count <= '0;
`ifdef MULT4_ACCUMULATOR_SATURATE_EN
      sat_acc   <= 1'b0;
      out_sat_q <= 1'b0;
`endif
    end else begin
      // P is empty on any cycle without an input transfer
      p_vld <= in_xfer;
      if (in_xfer) begin
        p_prod <= prod;
        p_last <= beat_final;
      end

      case (state)
        ACCUM: begin
          if (in_xfer) count <= count + 8'd1;
          // The final product stays in P and is folded in during FLUSH
          if (p_vld && !p_last) begin
            acc <= add_res;
`ifdef MULT4_ACCUMULATOR_SATURATE_EN
            sat_acc <= sat_acc | add_ovf;
`endif
          end
        end
        FLUSH: begin
          out_acc   <= add_res;
          out_count <= count;
          acc       <= '0;
          count     <= '0;
`ifdef MULT4_ACCUMULATOR_SATURATE_EN
          out_sat_q <= sat_acc | add_ovf;
          sat_acc   <= 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule
